// File: rtl/cmp_stack.sv
// cmp_stack: operand-stack compare unit. Keeps the top of stack in a register
// and the remaining entries in a single-port RAM with registered read. Executes
// PUSH, DROP, EQZ, EQ, NE and LT_U in i32 or i64 mode behind a valid/ready
// handshake, and raises sticky overflow/underflow/illegal-op traps.
//
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous active-low reset
//   op_valid     command present
//   op_ready     unit accepts a command this cycle (IDLE only)
//   op           opcode: 0 NOP, 1 PUSH, 2 DROP, 3 EQZ, 4 EQ, 5 NE, 6 LT_U, 7 illegal
//   op64         1 = i64 mode (only meaningful when WIDTH = 64)
//   op_data      PUSH operand
//   result       current top of stack, 0 when empty
//   result_empty stack holds no entries
//   count        number of entries
//   trap         0 none, 1 overflow, 2 underflow, 3 illegal op (sticky)
module cmp_stack #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       op,
  input  logic             op64,
  input  logic [WIDTH-1:0] op_data,
  output logic [WIDTH-1:0] result,
  output logic             result_empty,
  output logic [CW-1:0]    count,
  output logic [2:0]       trap
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam bit          IS64 = (WIDTH == 64);
  localparam logic [WIDTH-1:0] LO_MASK = WIDTH'(32'hFFFF_FFFF);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_TRAP  = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_PUSH = 3'd1,
    OP_DROP = 3'd2,
    OP_EQZ  = 3'd3,
    OP_EQ   = 3'd4,
    OP_NE   = 3'd5,
    OP_LTU  = 3'd6,
    OP_ILL  = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    TR_NONE = 3'd0,
    TR_OVF  = 3'd1,
    TR_UNF  = 3'd2,
    TR_ILL  = 3'd3
  } trap_e;

  state_e           state_q, state_next;
  logic [WIDTH-1:0] tos_q, tos_next;
  logic [CW-1:0]    count_q, count_next;
  trap_e            trap_q, trap_next;
  op_e              opq_q, opq_next;
  logic             mode_q, mode_next;
  logic             ready_q, empty_q;

  logic             ram_we, ram_re;
  logic [AW-1:0]    ram_addr;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] mem [DEPTH-1];

  logic             mode_in;
  logic [WIDTH-1:0] push_val, eqz_opnd, opmask, cmp_a, cmp_b;
  logic             cmp_res;

  // Incoming-command operand shaping (i32 mode masks to the low word)
  always_comb begin
    mode_in  = IS64 && op64;
    push_val = mode_in ? op_data : (op_data & LO_MASK);
    eqz_opnd = mode_in ? tos_q : (tos_q & LO_MASK);
  end

  // Binary compare on NOS (a) versus TOS (b) using the mode latched at accept
  always_comb begin
    opmask  = mode_q ? {WIDTH{1'b1}} : LO_MASK;
    cmp_a   = rd_data & opmask;
    cmp_b   = tos_q & opmask;
    cmp_res = 1'b0;
    case (opq_q)
      OP_EQ:   cmp_res = (cmp_a == cmp_b);
      OP_NE:   cmp_res = (cmp_a != cmp_b);
      OP_LTU:  cmp_res = (cmp_a < cmp_b);
      default: cmp_res = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_next;
  end

  // Next-state, datapath updates and RAM control
  always_comb begin
    state_next = state_q;
    tos_next   = tos_q;
    count_next = count_q;
    trap_next  = trap_q;
    opq_next   = opq_q;
    mode_next  = mode_q;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    ram_addr   = '0;

    case (state_q)
      ST_IDLE: begin
        if (op_valid) begin
          case (op)
            OP_NOP: ;
            OP_PUSH: begin
              if (count_q == CW'(DEPTH)) begin
                trap_next  = TR_OVF;
                state_next = ST_TRAP;
              end else begin
                if (count_q != '0) begin
                  ram_we   = 1'b1;
                  ram_addr = AW'(count_q - CW'(1));
                end
                tos_next   = push_val;
                count_next = count_q + CW'(1);
              end
            end
            OP_EQZ: begin
              if (count_q == '0) begin
                trap_next  = TR_UNF;
                state_next = ST_TRAP;
              end else begin
                tos_next = WIDTH'(eqz_opnd == '0);
              end
            end
            OP_DROP: begin
              if (count_q == '0) begin
                trap_next  = TR_UNF;
                state_next = ST_TRAP;
              end else begin
                // With a single entry there is no NOS; the read is skipped
                ram_re     = (count_q >= CW'(2));
                ram_addr   = AW'(count_q - CW'(2));
                opq_next   = OP_DROP;
                state_next = ST_FETCH;
              end
            end
            OP_EQ, OP_NE, OP_LTU: begin
              if (count_q < CW'(2)) begin
                trap_next  = TR_UNF;
                state_next = ST_TRAP;
              end else begin
                ram_re     = 1'b1;
                ram_addr   = AW'(count_q - CW'(2));
                opq_next   = op_e'(op);
                mode_next  = mode_in;
                state_next = ST_FETCH;
              end
            end
            default: begin
              trap_next  = TR_ILL;
              state_next = ST_TRAP;
            end
          endcase
        end
      end

      ST_FETCH: begin
        if (opq_q == OP_DROP) begin
          tos_next   = (count_q == CW'(1)) ? '0 : rd_data;
          count_next = count_q - CW'(1);
          state_next = ST_IDLE;
        end else begin
          state_next = ST_EXEC;
        end
      end

      ST_EXEC: begin
        tos_next   = WIDTH'(cmp_res);
        count_next = count_q - CW'(1);
        state_next = ST_IDLE;
      end

      ST_TRAP: ;

      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tos_q   <= '0;
      count_q <= '0;
      trap_q  <= TR_NONE;
      opq_q   <= OP_NOP;
      mode_q  <= 1'b0;
      ready_q <= 1'b1;
      empty_q <= 1'b1;
    end else begin
      tos_q   <= tos_next;
      count_q <= count_next;
      trap_q  <= trap_next;
      opq_q   <= opq_next;
      mode_q  <= mode_next;
      ready_q <= (state_next == ST_IDLE);
      empty_q <= (count_next == '0);
    end
  end

  // Single-port stack RAM, registered read; contents not reset
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= tos_q;
    if (ram_re) rd_data <= mem[ram_addr];
  end

  assign op_ready     = ready_q;
  assign result       = tos_q;
  assign result_empty = empty_q;
  assign count        = count_q;
  assign trap         = trap_q;

endmodule
